// File: rtl/record_play_if.sv
`default_nettype none
// ============================================================================
// Module      : record_play_if
// Description : Bundle between the record/play controller and its surroundings.
//               Carries the button pulses, memory status and memory control
//               strobes.
//               master : the controller (consumes buttons/status, drives
//                        memory control and state reporting)
//               slave  : the memory/button side (the reverse directions)
// Ports       : btn_* (1 each)       debounced one-cycle command pulses
//               mem_full              memory full flag, status only
//               mem_output_ready      selected unit still has notes
//               unit_status[MAX_UNITS] valid-track flags
//               mem_write_en/read_en/read_rst/save/discard/delete  controls
//               mem_select[SEL_W], ctrl_state[3], busy
// Revision    : 1.0  initial release
// ============================================================================
interface record_play_if #(
    parameter int SEL_W     = 4,
    parameter int MAX_UNITS = 9
);
    logic                 btn_rec;
    logic                 btn_stop;
    logic                 btn_play;
    logic                 btn_save;
    logic                 btn_discard;
    logic                 btn_delete;
    logic                 btn_next;
    logic                 btn_prev;
    logic                 mem_full;
    logic                 mem_output_ready;
    logic [MAX_UNITS-1:0] unit_status;

    logic                 mem_write_en;
    logic                 mem_read_en;
    logic                 mem_read_rst;
    logic                 mem_save;
    logic                 mem_discard;
    logic                 mem_delete;
    logic [SEL_W-1:0]     mem_select;
    logic [2:0]           ctrl_state;
    logic                 busy;

    modport master (
        input  btn_rec, btn_stop, btn_play, btn_save, btn_discard,
               btn_delete, btn_next, btn_prev, mem_full, mem_output_ready,
               unit_status,
        output mem_write_en, mem_read_en, mem_read_rst, mem_save,
               mem_discard, mem_delete, mem_select, ctrl_state, busy
    );

    modport slave (
        output btn_rec, btn_stop, btn_play, btn_save, btn_discard,
               btn_delete, btn_next, btn_prev, mem_full, mem_output_ready,
               unit_status,
        input  mem_write_en, mem_read_en, mem_read_rst, mem_save,
               mem_discard, mem_delete, mem_select, ctrl_state, busy
    );
endinterface
`default_nettype wire

// File: rtl/record_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : record_play_ctrl
// Description : Control FSM for a multi-unit note recorder/player. Records into
//               memory, saves/discards the take, deletes user tracks, plays the
//               selected unit and steps the selection through valid units.
//               Optional macro PLAYLIST_EN: at track end, advance to the next
//               valid unit and keep playing instead of returning to IDLE.
// Ports       : clk    - single clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - record_play_if.master (buttons, status, controls)
// Revision    : 1.0  initial release
// ============================================================================
module record_play_ctrl #(
    parameter int SEL_W        = 4,
    parameter int MAX_UNITS    = 9,
    parameter int PRE_WRITTEN  = 5,
    parameter int PULSE_CYCLES = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    record_play_if.master bus
);
    localparam int                 c_CNT_W       = $clog2(PULSE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_PULSE       = c_CNT_W'(PULSE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [SEL_W-1:0]   c_PRE_WRITTEN = SEL_W'(PRE_WRITTEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REC      = 3'd1,
        S_REC_HOLD = 3'd2,
        S_SAVE_P   = 3'd3,
        S_DISC_P   = 3'd4,
        S_PLAY_RST = 3'd5,
        S_PLAY     = 3'd6,
        S_DEL_P    = 3'd7
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rdy_d;
    logic               r_we;
    logic               r_re;
    logic               r_rrst;
    logic               r_save;
    logic               r_disc;
    logic               r_del;

    logic [SEL_W-1:0]   w_next_sel;
    logic [SEL_W-1:0]   w_prev_sel;
    int                 w_nidx;
    int                 w_pidx;
    logic               w_unused_full;

    // The full flag is informational; recording overwrites the oldest unit.
    assign w_unused_full = bus.mem_full;

    // Nearest valid unit in each direction (wrapping). Scanning from the
    // farthest distance down lets the closest hit win. If no other unit is
    // valid the selection stays where it is.
    always_comb begin
        w_next_sel = r_sel;
        w_prev_sel = r_sel;
        w_nidx     = 0;
        w_pidx     = 0;
        for (int k = MAX_UNITS - 1; k >= 1; k--) begin
            w_nidx = (int'(r_sel) + k) % MAX_UNITS;
            w_pidx = (int'(r_sel) + MAX_UNITS - k) % MAX_UNITS;
            if (bus.unit_status[w_nidx[SEL_W-1:0]]) begin
                w_next_sel = SEL_W'(w_nidx);
            end
            if (bus.unit_status[w_pidx[SEL_W-1:0]]) begin
                w_prev_sel = SEL_W'(w_pidx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rdy_d <= 1'b0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_rrst  <= 1'b0;
            r_save  <= 1'b0;
            r_disc  <= 1'b0;
            r_del   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Only the highest-priority pressed button is considered;
                    // if it is not applicable the others are still dropped.
                    if (bus.btn_rec) begin
                        r_state <= S_REC;
                        r_we    <= 1'b1;
                    end else if (bus.btn_play) begin
                        if (bus.unit_status[r_sel]) begin
                            r_state <= S_PLAY_RST;
                            r_rrst  <= 1'b1;
                        end
                    end else if (bus.btn_delete) begin
                        if ((r_sel >= c_PRE_WRITTEN) && bus.unit_status[r_sel]) begin
                            r_state <= S_DEL_P;
                            r_del   <= 1'b1;
                            r_cnt   <= c_CNT_ONE;
                        end
                    end else if (bus.btn_next) begin
                        r_sel <= w_next_sel;
                    end else if (bus.btn_prev) begin
                        r_sel <= w_prev_sel;
                    end
                end
                S_REC: begin
                    if (bus.btn_stop) begin
                        r_state <= S_REC_HOLD;
                        r_we    <= 1'b0;
                    end
                end
                S_REC_HOLD: begin
                    if (bus.btn_discard) begin
                        r_state <= S_DISC_P;
                        r_disc  <= 1'b1;
                        r_cnt   <= c_CNT_ONE;
                    end else if (bus.btn_save) begin
                        r_state <= S_SAVE_P;
                        r_save  <= 1'b1;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                S_SAVE_P, S_DISC_P, S_DEL_P: begin
                    // r_cnt counts strobe-high cycles already elapsed,
                    // starting at 1 on the entry cycle.
                    if (r_cnt == c_PULSE) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_save  <= 1'b0;
                        r_disc  <= 1'b0;
                        r_del   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PLAY_RST: begin
                    r_state <= S_PLAY;
                    r_rrst  <= 1'b0;
                    r_re    <= 1'b1;
                    // Clearing the history makes a low ready on the first
                    // PLAY cycle look like "no edge".
                    r_rdy_d <= 1'b0;
                end
                S_PLAY: begin
                    r_rdy_d <= bus.mem_output_ready;
                    if (bus.btn_stop) begin
                        r_state <= S_IDLE;
                        r_re    <= 1'b0;
                    end else if (r_rdy_d && !bus.mem_output_ready) begin
`ifdef PLAYLIST_EN
                        r_sel   <= w_next_sel;
                        r_state <= S_PLAY_RST;
                        r_re    <= 1'b0;
                        r_rrst  <= 1'b1;
`else
                        r_state <= S_IDLE;
                        r_re    <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_write_en = r_we;
    assign bus.mem_read_en  = r_re;
    assign bus.mem_read_rst = r_rrst;
    assign bus.mem_save     = r_save;
    assign bus.mem_discard  = r_disc;
    assign bus.mem_delete   = r_del;
    assign bus.mem_select   = r_sel;
    assign bus.ctrl_state   = r_state;
    assign bus.busy         = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_record_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_record_play_ctrl
// Description : Self-checking bench for record_play_ctrl. A cycle model of the
//               controller predicts state, selection and strobes for every
//               driven cycle; predictions are queued and compared after the
//               clock edge. Directed scenarios add strobe-length checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_record_play_ctrl;
    localparam int SEL_W     = 4;
    localparam int MAX_UNITS = 9;
    localparam int PRE_W     = 5;
    localparam int PULSE     = 4;

    localparam logic [7:0] B_REC  = 8'h01;
    localparam logic [7:0] B_STOP = 8'h02;
    localparam logic [7:0] B_PLAY = 8'h04;
    localparam logic [7:0] B_SAVE = 8'h08;
    localparam logic [7:0] B_DISC = 8'h10;
    localparam logic [7:0] B_DEL  = 8'h20;
    localparam logic [7:0] B_NEXT = 8'h40;
    localparam logic [7:0] B_PREV = 8'h80;

    typedef struct packed {
        logic [2:0]       st;
        logic [SEL_W-1:0] sel;
        logic [5:0]       strb;   // {we, re, rrst, save, disc, del}
        logic             busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t q[$];

    // model state
    logic [2:0]       m_state;
    logic [SEL_W-1:0] m_sel;
    int               m_cnt;
    logic             m_rdy_d;

    // strobe-high cycle counters observed on the DUT
    int n_we, n_save, n_disc, n_del, n_rrst;

    record_play_if #(.SEL_W(SEL_W), .MAX_UNITS(MAX_UNITS)) bus ();

    record_play_ctrl #(
        .SEL_W       (SEL_W),
        .MAX_UNITS   (MAX_UNITS),
        .PRE_WRITTEN (PRE_W),
        .PULSE_CYCLES(PULSE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=0x%0h req=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [SEL_W-1:0] m_search(input logic [SEL_W-1:0] s, input bit fwd,
                                                   input logic [MAX_UNITS-1:0] us);
        int i;
        i = int'(s);
        for (int n = 0; n < MAX_UNITS - 1; n++) begin
            if (fwd) i = (i == MAX_UNITS - 1) ? 0 : i + 1;
            else     i = (i == 0) ? MAX_UNITS - 1 : i - 1;
            if (us[i]) return i[SEL_W-1:0];
        end
        return s;
    endfunction

    function automatic exp_t m_exp();
        exp_t e;
        e.st   = m_state;
        e.sel  = m_sel;
        e.busy = (m_state != 3'd0);
        case (m_state)
            3'd1:    e.strb = 6'b100000;
            3'd6:    e.strb = 6'b010000;
            3'd5:    e.strb = 6'b001000;
            3'd3:    e.strb = 6'b000100;
            3'd4:    e.strb = 6'b000010;
            3'd7:    e.strb = 6'b000001;
            default: e.strb = 6'b000000;
        endcase
        return e;
    endfunction

    task automatic m_reset();
        m_state = 3'd0;
        m_sel   = '0;
        m_cnt   = 0;
        m_rdy_d = 1'b0;
        q.delete();
    endtask

    // Advances the model by one clock edge given the inputs present at it.
    task automatic m_step(input logic [7:0] b);
        logic [MAX_UNITS-1:0] us;
        logic rdy;
        us  = bus.unit_status;
        rdy = bus.mem_output_ready;
        case (m_state)
            3'd0: begin
                if (b[0]) m_state = 3'd1;
                else if (b[2]) begin
                    if (us[m_sel]) m_state = 3'd5;
                end else if (b[5]) begin
                    if (int'(m_sel) >= PRE_W && us[m_sel]) begin
                        m_state = 3'd7;
                        m_cnt   = 0;
                    end
                end else if (b[6]) m_sel = m_search(m_sel, 1'b1, us);
                else if (b[7]) m_sel = m_search(m_sel, 1'b0, us);
            end
            3'd1: if (b[1]) m_state = 3'd2;
            3'd2: begin
                if (b[4]) begin
                    m_state = 3'd4;
                    m_cnt   = 0;
                end else if (b[3]) begin
                    m_state = 3'd3;
                    m_cnt   = 0;
                end
            end
            3'd3, 3'd4, 3'd7: begin
                m_cnt++;
                if (m_cnt == PULSE) m_state = 3'd0;
            end
            3'd5: begin
                m_state = 3'd6;
                m_rdy_d = 1'b0;
            end
            3'd6: begin
                if (b[1]) m_state = 3'd0;
                else if (m_rdy_d && !rdy) begin
`ifdef PLAYLIST_EN
                    m_sel   = m_search(m_sel, 1'b1, us);
                    m_state = 3'd5;
`else
                    m_state = 3'd0;
`endif
                end
                m_rdy_d = rdy;
            end
            default: m_state = 3'd0;
        endcase
    endtask

    task automatic set_btns(input logic [7:0] b);
        bus.btn_rec     = b[0];
        bus.btn_stop    = b[1];
        bus.btn_play    = b[2];
        bus.btn_save    = b[3];
        bus.btn_discard = b[4];
        bus.btn_delete  = b[5];
        bus.btn_next    = b[6];
        bus.btn_prev    = b[7];
    endtask

    task automatic clr_counts();
        n_we = 0; n_save = 0; n_disc = 0; n_del = 0; n_rrst = 0;
    endtask

    // One clock: drive buttons, queue the prediction, compare after the edge.
    task automatic step(input logic [7:0] b);
        exp_t e;
        set_btns(b);
        m_step(b);
        q.push_back(m_exp());
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check("ctrl_state", 32'(bus.ctrl_state), 32'(e.st));
            check("mem_select", 32'(bus.mem_select), 32'(e.sel));
            check("strobes", 32'({bus.mem_write_en, bus.mem_read_en, bus.mem_read_rst,
                                  bus.mem_save, bus.mem_discard, bus.mem_delete}),
                  32'(e.strb));
            check("busy", 32'(bus.busy), 32'(e.busy));
        end
        n_we   += int'(bus.mem_write_en);
        n_save += int'(bus.mem_save);
        n_disc += int'(bus.mem_discard);
        n_del  += int'(bus.mem_delete);
        n_rrst += int'(bus.mem_read_rst);
        set_btns(8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr_counts();
        m_reset();
        set_btns(8'h00);
        bus.mem_full         = 1'b0;
        bus.mem_output_ready = 1'b0;
        bus.unit_status      = 9'b000101111;
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(bus.ctrl_state), 32'd0);
        check("rst_sel", 32'(bus.mem_select), 32'd0);
        check("rst_strobes", 32'({bus.mem_write_en, bus.mem_read_en, bus.mem_read_rst,
                                  bus.mem_save, bus.mem_discard, bus.mem_delete}), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // record 10 cycles then save (mem_full must not matter)
        clr_counts();
        bus.mem_full = 1'b1;
        step(B_REC);
        bus.mem_full = 1'b0;
        step(B_PLAY | B_NEXT);          // ignored while recording
        idle(8);
        step(B_STOP);
        step(B_SAVE);
        idle(5);
        check("rec_we_cycles", 32'(n_we), 32'd10);
        check("save_cycles", 32'(n_save), 32'd4);
        check("after_save_state", 32'(bus.ctrl_state), 32'd0);

        // save and discard together: discard wins
        clr_counts();
        step(B_REC | B_PLAY | B_NEXT);  // rec has priority
        idle(2);
        step(B_STOP);
        step(B_SAVE | B_DISC);
        idle(5);
        check("disc_cycles", 32'(n_disc), 32'd4);
        check("disc_no_save", 32'(n_save), 32'd0);

        // navigation: go to unit 3, then next, next, prev
        step(B_NEXT); step(B_NEXT); step(B_NEXT);
        check("nav_at3", 32'(bus.mem_select), 32'd3);
        step(B_NEXT);
        check("nav_next5", 32'(bus.mem_select), 32'd5);
        step(B_NEXT);
        check("nav_wrap0", 32'(bus.mem_select), 32'd0);
        step(B_PREV);
        check("nav_prev5", 32'(bus.mem_select), 32'd5);

        // delete: factory unit ignored, user unit pulses
        step(B_PREV); step(B_PREV);
        check("del_at2", 32'(bus.mem_select), 32'd2);
        clr_counts();
        step(B_DEL);
        idle(2);
        check("del_factory", 32'(n_del), 32'd0);
        step(B_NEXT); step(B_NEXT);
        clr_counts();
        step(B_DEL | B_NEXT);           // delete beats next
        idle(5);
        check("del_cycles", 32'(n_del), 32'd4);
        bus.unit_status = 9'b000001111;

        // play unit 0, then track end
        step(B_NEXT);
        check("play_sel0", 32'(bus.mem_select), 32'd0);
        bus.mem_output_ready = 1'b1;
        clr_counts();
        step(B_PLAY);
        idle(3);
        check("play_rrst_once", 32'(n_rrst), 32'd1);
        bus.mem_output_ready = 1'b0;
        step(8'h00);
`ifdef PLAYLIST_EN
        check("end_sel", 32'(bus.mem_select), 32'd1);
        check("end_rrst_again", 32'(bus.mem_read_rst), 32'd1);
`else
        check("end_sel", 32'(bus.mem_select), 32'd0);
        check("end_idle", 32'(bus.ctrl_state), 32'd0);
`endif
        for (int i = 0; i < 4 && m_state != 3'd0; i++) step(B_STOP);

        // ready low on the first PLAY cycle is not a track end
        step(B_PLAY);
        idle(3);
        check("play_low_start", 32'(bus.ctrl_state), 32'd6);
        bus.mem_output_ready = 1'b1;
        idle(2);
        step(B_STOP);
        check("play_stop", 32'(bus.ctrl_state), 32'd0);

        // play on an invalid unit is ignored; next with no other valid unit
        bus.unit_status = 9'b000001111 & ~(9'b1 << m_sel);
        step(B_PLAY);
        check("play_invalid", 32'(bus.ctrl_state), 32'd0);
        bus.unit_status = 9'b1 << m_sel;
        step(B_NEXT);
        step(B_PREV);
        bus.unit_status = 9'b000101111;

        // async reset in the second cycle of a save pulse
        step(B_NEXT);
        step(B_REC);
        step(B_STOP);
        step(B_SAVE);
        step(8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_save", 32'(bus.mem_save), 32'd0);
        check("rst_mid_state", 32'(bus.ctrl_state), 32'd0);
        check("rst_mid_sel", 32'(bus.mem_select), 32'd0);
        m_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] b;
            b = 8'h00;
            if ($urandom_range(0, 2) == 0) b[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 7) == 0) b[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 5) == 0) bus.mem_output_ready = ~bus.mem_output_ready;
            if ($urandom_range(0, 40) == 0) bus.unit_status = 9'($urandom());
            bus.mem_full = 1'($urandom_range(0, 1));
            step(b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/record_play_ctrl.md
RECORD_PLAY_CTRL -- requirements
Module: record_play_ctrl

Interface
REQ-001 SHALL have parameter SEL_W, default 4: width of mem_select; holds unit indices 0..MAX_UNITS-1.
REQ-002 SHALL have parameter MAX_UNITS, default 9: number of memory units.
REQ-003 SHALL have parameter PRE_WRITTEN, default 5: units 0..PRE_WRITTEN-1 are factory tracks and cannot be deleted.
REQ-004 SHALL have parameter PULSE_CYCLES, default 4: high time of the save, discard and delete strobes.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 btn_rec, btn_stop, btn_play, btn_save, btn_discard, btn_delete, btn_next, btn_prev  in  1 each  debounced one-cycle command pulses.
REQ-008 mem_full  in  1  memory full flag; status only.
REQ-009 mem_output_ready  in  1  high while the selected unit has notes left; a 1->0 edge during PLAY marks track end.
REQ-010 unit_status  in  MAX_UNITS  bit i high = unit i holds a valid track.
REQ-011 mem_write_en, mem_read_en, mem_read_rst, mem_save, mem_discard, mem_delete  out  1 each  memory control.
REQ-012 mem_select  out  SEL_W  selected unit; ctrl_state  out  3  current FSM state code; busy  out  1  high when not IDLE.

Function
REQ-013 FSM states SHALL be IDLE=0, REC=1, REC_HOLD=2, SAVE_P=3, DISC_P=4, PLAY_RST=5, PLAY=6, DEL_P=7; ctrl_state equals the code.
REQ-014 IDLE command priority for same-cycle buttons SHALL be rec > play > delete > next > prev; lower-priority buttons that cycle are dropped.
REQ-015 IDLE + btn_rec -> REC regardless of mem_full (memory overwrites the oldest user unit).
REQ-016 REC: mem_write_en=1 every cycle; btn_stop -> REC_HOLD; all other buttons ignored.
REQ-017 REC_HOLD: mem_write_en=0; btn_discard -> DISC_P; else btn_save -> SAVE_P; discard wins when both are pressed.
REQ-018 SAVE_P, DISC_P and DEL_P SHALL drive mem_save, mem_discard and mem_delete respectively high for exactly PULSE_CYCLES cycles, then return to IDLE with the strobe low; buttons are ignored meanwhile.
REQ-019 IDLE + btn_delete SHALL go to DEL_P only if mem_select >= PRE_WRITTEN and unit_status[mem_select]=1; otherwise the button is ignored.
REQ-020 IDLE + btn_play with unit_status[mem_select]=1 -> PLAY_RST; with unit_status[mem_select]=0 the button is ignored.
REQ-021 PLAY_RST: mem_read_rst=1 for exactly 1 cycle, then PLAY.
REQ-022 PLAY: mem_read_en=1; btn_stop -> IDLE next cycle; a mem_output_ready 1->0 edge -> IDLE (see REQ-027); mem_output_ready low on the first PLAY cycle is not an edge.
REQ-023 btn_next/btn_prev SHALL act only in IDLE: move mem_select to the next/previous index with unit_status=1, wrapping MAX_UNITS-1<->0, resolved in one cycle; mem_select is unchanged if no other valid unit exists.
REQ-024 mem_select SHALL change only per REQ-023 and REQ-027; it is held constant in all other states.
REQ-025 At most one of mem_write_en, mem_read_en, mem_read_rst, mem_save, mem_discard, mem_delete SHALL be high in any cycle; all are registered outputs.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, mem_select=0, every strobe and enable low, and the pulse counter to 0, including mid-pulse and mid-REC. Operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-027 Macro PLAYLIST_EN: when defined, track end in PLAY advances mem_select per the REQ-023 next rule and enters PLAY_RST; if no other valid unit exists, the same unit replays; btn_stop still -> IDLE. When undefined, track end -> IDLE and mem_select is unchanged.

Verification
REQ-028 Reset then btn_rec, 10 cycles, btn_stop, btn_save -> mem_write_en high 10 cycles; mem_save high exactly 4 cycles; back to IDLE; ctrl_state=0.
REQ-029 REC_HOLD with btn_save and btn_discard in the same cycle -> mem_discard high 4 cycles, mem_save never high.
REQ-030 unit_status=9'b000101111, mem_select=3, btn_next x2 -> mem_select=5 then 0; btn_prev -> 5.
REQ-031 mem_select=2, btn_delete -> no strobe; mem_select=5, unit_status[5]=1, btn_delete -> mem_delete high 4 cycles.
REQ-032 btn_play on unit 0, then drop mem_output_ready -> mem_read_rst 1 cycle then mem_read_en; without PLAYLIST_EN -> IDLE with mem_select=0; with PLAYLIST_EN -> mem_select=1 and mem_read_rst pulses again.
REQ-033 rst_n low during the 2nd cycle of a mem_save pulse -> mem_save low immediately, ctrl_state=0, mem_select=0.
